// File: rtl/gray_count_checker.sv
// Gray-code count monitor: decodes a sampled Gray bus and flags any change that is not +1.
// Define GRAY_CHK_SYNC_EN to add a two-flop synchroniser in front of the sampling stage.
module gray_count_checker #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 clear_err,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    output logic                 step,
    output logic                 wrap,
    output logic                 err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic [WIDTH-1:0] s1_src;

`ifdef GRAY_CHK_SYNC_EN
    // Only one bit changes per count, so the captured value is always the old or new count.
    logic [WIDTH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gray_in;
            sync2_q <= sync1_q;
        end
    end

    assign s1_src = sync2_q;
`else
    assign s1_src = gray_in;
`endif

    logic [WIDTH-1:0]     g_q;
    logic                 v1_q;
    logic [WIDTH-1:0]     bin_q, bin_d;
    logic                 valid_q, valid_d;
    logic                 step_q, step_d;
    logic                 wrap_q, wrap_d;
    logic                 err_q, err_d;
    logic                 sticky_q, sticky_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     dec;

    always_comb begin
        dec = '0;
        dec[WIDTH-1] = g_q[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            dec[i] = dec[i+1] ^ g_q[i];
        end
    end

    always_comb begin
        bin_d    = bin_q;
        valid_d  = valid_q;
        step_d   = 1'b0;
        wrap_d   = 1'b0;
        err_d    = 1'b0;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (v1_q) begin
            bin_d   = dec;
            valid_d = 1'b1;
            if (valid_q && dec != bin_q) begin
                if (dec == bin_q + 1'b1) begin
                    step_d = 1'b1;
                    wrap_d = &bin_q;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
        // A fresh error in the clearing cycle survives the clear as the first counted error.
        if (err_d) begin
            sticky_d = 1'b1;
            if (clear_err) begin
                cnt_d = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end else if (!(&cnt_q)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (clear_err) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            g_q      <= '0;
            v1_q     <= 1'b0;
            bin_q    <= '0;
            valid_q  <= 1'b0;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            g_q      <= s1_src;
            v1_q     <= 1'b1;
            bin_q    <= bin_d;
            valid_q  <= valid_d;
            step_q   <= step_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bin_out    = bin_q;
    assign bin_valid  = valid_q;
    assign step       = step_q;
    assign wrap       = wrap_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign err_count  = cnt_q;

endmodule

// File: tb/tb_gray_count_checker.sv
// Directed bench for gray_count_checker in its default build (no synchroniser).
module tb_gray_count_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] gray_in;
    logic       clear_err;
    logic [7:0] bin_out;
    logic       bin_valid, step, wrap, err, err_sticky;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    gray_count_checker #(.WIDTH(8), .ERR_CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_in    (gray_in),
        .clear_err  (clear_err),
        .bin_out    (bin_out),
        .bin_valid  (bin_valid),
        .step       (step),
        .wrap       (wrap),
        .err        (err),
        .err_sticky (err_sticky),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse-and-status snapshot: bin_out, step, wrap, err, sticky, count.
    task automatic chk_all(input string tag, input logic [7:0] b, input logic s, input logic w,
                           input logic e, input logic st, input logic [7:0] c);
        chk({tag, ".bin"},    {24'd0, bin_out},   {24'd0, b});
        chk({tag, ".step"},   {31'd0, step},      {31'd0, s});
        chk({tag, ".wrap"},   {31'd0, wrap},      {31'd0, w});
        chk({tag, ".err"},    {31'd0, err},       {31'd0, e});
        chk({tag, ".sticky"}, {31'd0, err_sticky}, {31'd0, st});
        chk({tag, ".cnt"},    {24'd0, err_count}, {24'd0, c});
    endtask

    initial begin
        reset = 1'b1; gray_in = 8'h00; clear_err = 1'b0;
        tick(); tick();
        chk_all("rst", 8'h00, 0, 0, 0, 0, 8'd0);
        chk("rst.valid", {31'd0, bin_valid}, 32'd0);

        // Priming: valid at second edge after release.
        reset = 1'b0;
        tick();
        chk("prime1.valid", {31'd0, bin_valid}, 32'd0);
        tick();
        chk("prime2.valid", {31'd0, bin_valid}, 32'd1);
        chk_all("prime2", 8'h00, 0, 0, 0, 0, 8'd0);
        tick();
        chk_all("hold", 8'h00, 0, 0, 0, 0, 8'd0);

        // Back-to-back increments 0..4.
        gray_in = 8'h01; tick();
        gray_in = 8'h03; tick(); chk_all("inc1", 8'd1, 1, 0, 0, 0, 8'd0);
        gray_in = 8'h02; tick(); chk_all("inc2", 8'd2, 1, 0, 0, 0, 8'd0);
        gray_in = 8'h06; tick(); chk_all("inc3", 8'd3, 1, 0, 0, 0, 8'd0);
        tick();                  chk_all("inc4", 8'd4, 1, 0, 0, 0, 8'd0);
        tick();                  chk_all("inc_hold", 8'd4, 0, 0, 0, 0, 8'd0);

        // Step to 5, then illegal jump to 8, then legal step to 9.
        gray_in = 8'h07; tick(); tick(); chk_all("to5", 8'd5, 1, 0, 0, 0, 8'd0);
        gray_in = 8'h0C; tick(); tick(); chk_all("jump8", 8'd8, 0, 0, 1, 1, 8'd1);
        gray_in = 8'h0D; tick(); tick(); chk_all("step9", 8'd9, 1, 0, 0, 1, 8'd1);

        // 9 -> 254 is an error; then 254 -> 255 -> 0 wraps.
        gray_in = 8'h81; tick();
        gray_in = 8'h80; tick(); chk_all("to254", 8'd254, 0, 0, 1, 1, 8'd2);
        gray_in = 8'h00; tick(); chk_all("to255", 8'd255, 1, 0, 0, 1, 8'd2);
        tick();                  chk_all("wrap0", 8'd0, 1, 1, 0, 1, 8'd2);
        tick();                  chk_all("wrap_hold", 8'd0, 0, 0, 0, 1, 8'd2);

        clear_err = 1'b1; tick(); clear_err = 1'b0;
        chk_all("clear", 8'd0, 0, 0, 0, 0, 8'd0);

        // 300 alternating 0 <-> 128 jumps, each one an error.
        for (int i = 0; i < 300; i++) begin
            gray_in = (i % 2 == 0) ? 8'hC0 : 8'h00;
            tick();
        end
        gray_in = 8'hC0; tick();
        chk_all("sat", 8'd0, 0, 0, 1, 1, 8'd255);
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        chk_all("clr_vs_err", 8'd128, 0, 0, 1, 1, 8'd1);

        // Mid-operation reset, then re-prime on an arbitrary value.
        gray_in = 8'hC1;
        reset = 1'b1; tick(); reset = 1'b0;
        chk_all("mid_rst", 8'd0, 0, 0, 0, 0, 8'd0);
        chk("mid_rst.valid", {31'd0, bin_valid}, 32'd0);
        gray_in = 8'h55; tick();
        chk("reprime1.valid", {31'd0, bin_valid}, 32'd0);
        tick();
        chk("reprime2.valid", {31'd0, bin_valid}, 32'd1);
        chk_all("reprime2", 8'h66, 0, 0, 0, 0, 8'd0);
        gray_in = 8'h54; tick(); tick();
        chk_all("after_reprime", 8'h67, 1, 0, 0, 0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
